rom_16x8: RTL and testbench
===========================

Name: rom_16x8

Overview:
- Synchronous read-only memory: 16 words x 8 bits, fixed contents.
- One registered read port with read enable. One clock cycle from address to data.
- Used as a constant lookup table. The client drives address and enable on the falling clock edge; the ROM samples them on the rising edge.

Parameters:
- ADDR_W, 4, address width; depth is 2**ADDR_W = 16.
- DATA_W, 8, data word width.

Ports:
- Clk  input  1  system clock; all sampling on the rising edge.
- Rst  input  1  asynchronous, active-high reset.
- Re  input  1  read enable, active high.
- Ra  input  ADDR_W  read address.
- Dout  output  DATA_W  registered read data.

Behaviour:
- Contents are fixed at elaboration and never writable.
- Word at address i is {i[3:0], ~i[3:0]}:
  - addr 0 -> 8'h0F, 1 -> 8'h1E, 2 -> 8'h2D, 3 -> 8'h3C
  - addr 4 -> 8'h4B, 5 -> 8'h5A, 6 -> 8'h69, 7 -> 8'h78
  - addr 8 -> 8'h87, 9 -> 8'h96, 10 -> 8'hA5, 11 -> 8'hB4
  - addr 12 -> 8'hC3, 13 -> 8'hD2, 14 -> 8'hE1, 15 -> 8'hF0
- Reset: Rst high forces Dout to 8'h00 immediately, regardless of Clk. Dout stays 8'h00 while Rst is high.
- Read: on a rising Clk edge with Rst low and Re = 1, Dout takes ROM[Ra] as sampled at that edge. Latency is one cycle. Dout is stable for the whole following cycle.
- Hold: on a rising edge with Re = 0, Dout keeps its previous value; it does not clear.
- Back-to-back reads are allowed every cycle with any address sequence, including repeats and the wrap from 15 to 0.
- All 2**ADDR_W addresses are valid. There is no out-of-range case and no error output.
- Reset release: the first rising edge after Rst falls follows the normal read/hold rules. If Re = 0 at that edge, Dout remains 8'h00.
- Reset mid-read: Rst asserted in the same cycle as Re overrides the read. Dout is 8'h00 and the read is discarded.
- X on Ra while Re = 0 must not disturb Dout.
- No combinational path from Ra or Re to Dout.

Decomposition:
- Package rom_pkg holds:
  - ADDR_W and DATA_W defaults.
  - Depth constant ROM_DEPTH = 16.
  - Constant function rom_word(addr) returning {addr, ~addr}, shared by the RTL and the bench's reference model.
- Sub-module rom_lut: purely combinational, address in, word out, implemented as a case table over all 16 entries.
- Top rom_16x8: the enable-gated output register with asynchronous reset, around rom_lut.

Test Plan:
- Reset: assert Rst for 20 ns with Re = 0 and Ra = 0 -> Dout = 8'h00 during and after reset until the first enabled read.
- Sequential sweep: Clk period 20 ns; from the first falling edge after reset, drive Re = 1 and Ra = 0..15 on successive falling edges -> on each next rising edge Dout = {Ra, ~Ra}, i.e. 8'h0F, 8'h1E, ..., 8'hF0 in order.
- Hold: read addr 5 (Dout = 8'h5A), then drive Re = 0 with Ra = 9 for 3 cycles -> Dout stays 8'h5A.
- Random order and repeats: read addresses 15, 0, 0, 7, 15 back-to-back -> 8'hF0, 8'h0F, 8'h0F, 8'h78, 8'hF0, each one cycle after its address.
- Async reset mid-operation: during a sweep, pulse Rst high between clock edges -> Dout drops to 8'h00 without waiting for an edge. After release, the next read of addr 10 -> 8'hA5.
- Reset with Re high: hold Re = 1, Ra = 3 while Rst = 1 across two rising edges -> Dout stays 8'h00. On the first edge after release -> 8'h3C.

Source files
------------

// File: rtl/rom_pkg.sv
// Shared constants and the reference word function for the 16x8 constant ROM.
package rom_pkg;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;
  localparam int ROM_DEPTH  = 16;

  function automatic logic [DEF_DATA_W-1:0] rom_word(input logic [DEF_ADDR_W-1:0] addr);
    return {addr, ~addr};
  endfunction
endpackage

// File: rtl/rom_16x8_if.sv
// Read-port bundle: client drives enable and address, ROM returns registered data.
interface rom_16x8_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              Re;
  logic [ADDR_W-1:0] Ra;
  logic [DATA_W-1:0] Dout;

  modport master (output Re, output Ra, input Dout);
  modport slave  (input Re, input Ra, output Dout);
endinterface

// File: rtl/rom_lut.sv
// Combinational lookup table: address in, fixed word out.
module rom_lut
  import rom_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] word
);
  always_comb begin
    word = '0;
    case (addr)
      4'd0:  word = 8'h0F;
      4'd1:  word = 8'h1E;
      4'd2:  word = 8'h2D;
      4'd3:  word = 8'h3C;
      4'd4:  word = 8'h4B;
      4'd5:  word = 8'h5A;
      4'd6:  word = 8'h69;
      4'd7:  word = 8'h78;
      4'd8:  word = 8'h87;
      4'd9:  word = 8'h96;
      4'd10: word = 8'hA5;
      4'd11: word = 8'hB4;
      4'd12: word = 8'hC3;
      4'd13: word = 8'hD2;
      4'd14: word = 8'hE1;
      4'd15: word = 8'hF0;
      default: word = '0;
    endcase
  end
endmodule

// File: rtl/rom_16x8.sv
// 16x8 constant ROM with one enable-gated registered read port.
module rom_16x8
  import rom_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input logic        Clk,
  input logic        Rst,
  rom_16x8_if.slave  bus
);
  logic [DATA_W-1:0] lut_word;

  rom_lut #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_lut (
    .addr (bus.Ra),
    .word (lut_word)
  );

  // Register only loads on Re, so an undriven Ra with Re low never reaches Dout.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)
      bus.Dout <= '0;
    else if (bus.Re)
      bus.Dout <= lut_word;
  end
endmodule

// File: tb/tb_rom_16x8.sv
// Directed bench for rom_16x8: reset, sweep, hold, repeats, async reset, reset over enable.
module tb_rom_16x8;
  import rom_pkg::*;

  logic Clk = 1'b0;
  logic Rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  rom_16x8_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  rom_16x8 #(.ADDR_W(4), .DATA_W(8)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #10 Clk = ~Clk;

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive on the falling edge, check 1 ns after the following rising edge.
  task automatic step(input logic re, input logic [3:0] ra, input logic [7:0] expected, input string tag);
    @(negedge Clk);
    bus.Re = re;
    bus.Ra = ra;
    @(posedge Clk);
    #1;
    check(tag, bus.Dout, expected);
  endtask

  initial begin
    Rst    = 1'b1;
    bus.Re = 1'b0;
    bus.Ra = 4'd0;
    #5;
    check("reset_during", bus.Dout, 8'h00);
    #15;
    Rst = 1'b0;
    #1;
    check("reset_release", bus.Dout, 8'h00);
    @(posedge Clk);
    #1;
    check("first_edge_re0", bus.Dout, 8'h00);

    for (int i = 0; i < ROM_DEPTH; i++)
      step(1'b1, 4'(i), rom_word(4'(i)), $sformatf("sweep_%0d", i));

    step(1'b1, 4'd5, 8'h5A, "hold_load");
    for (int i = 0; i < 3; i++)
      step(1'b0, 4'd9, 8'h5A, $sformatf("hold_%0d", i));
    step(1'b0, 4'bxxxx, 8'h5A, "hold_ra_x");

    step(1'b1, 4'd15, 8'hF0, "rand_15a");
    step(1'b1, 4'd0,  8'h0F, "rand_0a");
    step(1'b1, 4'd0,  8'h0F, "rand_0b");
    step(1'b1, 4'd7,  8'h78, "rand_7");
    step(1'b1, 4'd15, 8'hF0, "rand_15b");

    step(1'b1, 4'd12, 8'hC3, "pre_async");
    #4;
    Rst = 1'b1;
    #1;
    check("async_drop", bus.Dout, 8'h00);
    #3;
    Rst = 1'b0;
    #1;
    check("async_released", bus.Dout, 8'h00);
    step(1'b1, 4'd10, 8'hA5, "after_async");

    @(negedge Clk);
    Rst    = 1'b1;
    bus.Re = 1'b1;
    bus.Ra = 4'd3;
    @(posedge Clk);
    #1;
    check("rst_re_edge1", bus.Dout, 8'h00);
    @(posedge Clk);
    #1;
    check("rst_re_edge2", bus.Dout, 8'h00);
    @(negedge Clk);
    Rst = 1'b0;
    @(posedge Clk);
    #1;
    check("rst_re_release", bus.Dout, 8'h3C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
